cache_repl_mt: RTL

Parametrised age-based LRU replacement unit for set-associative L1 caches, for both instruction and data caches. It supports N hardware threads, each owning a programmable way mask, rather than fixed contiguous slices. Victim selection prefers invalid ways and is registered, returning a result one cycle after the request. Two update ports are provided: a hit port and a memory-fill port.

---
 rtl/cache_repl_mt.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cache_repl_mt.sv
// Age-based LRU replacement unit with per-thread way partitions and a registered victim pick.
// Optional way locking is enabled by defining CACHE_REPL_LOCK_EN.
module cache_repl_mt #(
  parameter int unsigned NUM_SET      = 4,
  parameter int unsigned WAYS_PER_SET = 8,
  parameter int unsigned NUM_THREADS  = 2,
  parameter int unsigned NUM_SET_W    = $clog2(NUM_SET),
  parameter int unsigned WAYS_W       = $clog2(WAYS_PER_SET),
  parameter int unsigned THR_W        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mt_enable,
  input  logic                    cfg_we,
  input  logic [THR_W-1:0]        cfg_thread,
  input  logic [WAYS_PER_SET-1:0] cfg_mask,
  input  logic                    victim_req,
  input  logic [NUM_SET_W-1:0]    victim_set,
  input  logic [THR_W-1:0]        victim_thread,
  input  logic [WAYS_PER_SET-1:0] valid_ways,
  output logic                    victim_valid,
  output logic [WAYS_W-1:0]       victim_way,
  output logic                    victim_none,
  input  logic                    hit_req,
  input  logic [NUM_SET_W-1:0]    hit_set,
  input  logic [WAYS_W-1:0]       hit_way,
  input  logic [THR_W-1:0]        hit_thread,
  input  logic                    fill_req,
  input  logic [NUM_SET_W-1:0]    fill_set,
  input  logic [WAYS_W-1:0]       fill_way,
  input  logic [THR_W-1:0]        fill_thread
`ifdef CACHE_REPL_LOCK_EN
  ,
  input  logic [NUM_SET_W-1:0]    lock_set,
  input  logic [WAYS_W-1:0]       lock_way,
  input  logic                    lock_en,
  input  logic                    lock_val
`endif
);

  typedef logic [WAYS_PER_SET-1:0][WAYS_W-1:0] row_t;
  typedef logic [WAYS_PER_SET-1:0]             wmask_t;

  localparam int unsigned SLICE = WAYS_PER_SET / NUM_THREADS;

  row_t   age_q [NUM_SET];
  row_t   age_d [NUM_SET];
  wmask_t mask_q [NUM_THREADS];

`ifdef CACHE_REPL_LOCK_EN
  wmask_t lock_q [NUM_SET];
`endif

  function automatic logic set_ok(input logic [NUM_SET_W-1:0] s);
    return 32'(s) < NUM_SET;
  endfunction

  function automatic wmask_t part(input logic [THR_W-1:0] t);
    if (!mt_enable)
      return '1;
    if (32'(t) < NUM_THREADS)
      return mask_q[t];
    return '0;
  endfunction

  // Ages only move up for ways younger than the touched one, so the saturation
  // guard never fires on a consistent row; it protects against stale partitions.
  function automatic row_t touch(input row_t row, input logic [WAYS_W-1:0] w, input wmask_t p);
    row_t r;
    r = row;
    for (int unsigned x = 0; x < WAYS_PER_SET; x++) begin
      if (p[x] && (x != 32'(w)) && (row[x] < row[w]) && (row[x] != '1))
        r[x] = row[x] + 1'b1;
    end
    r[w] = '0;
    return r;
  endfunction

  // Fill is applied on top of the hit result so a same-set pair chains in one write.
  always_comb begin
    for (int unsigned s = 0; s < NUM_SET; s++)
      age_d[s] = age_q[s];
    if (hit_req && set_ok(hit_set))
      age_d[hit_set] = touch(age_d[hit_set], hit_way, part(hit_thread));
    if (fill_req && set_ok(fill_set))
      age_d[fill_set] = touch(age_d[fill_set], fill_way, part(fill_thread));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SET; s++)
        for (int unsigned w = 0; w < WAYS_PER_SET; w++)
          age_q[s][w] <= WAYS_W'(w);
    end else begin
      for (int unsigned s = 0; s < NUM_SET; s++)
        age_q[s] <= age_d[s];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++)
        for (int unsigned w = 0; w < WAYS_PER_SET; w++)
          mask_q[t][w] <= (w >= t * SLICE) && (w < (t + 1) * SLICE);
    end else if (cfg_we && (32'(cfg_thread) < NUM_THREADS)) begin
      mask_q[cfg_thread] <= cfg_mask;
    end
  end

`ifdef CACHE_REPL_LOCK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SET; s++)
        lock_q[s] <= '0;
    end else if (lock_en && set_ok(lock_set)) begin
      lock_q[lock_set][lock_way] <= lock_val;
    end
  end
`endif

  wmask_t            elig;
  wmask_t            inv;
  row_t              vrow;
  logic [WAYS_W-1:0] pick;
  logic [WAYS_W-1:0] best_age;
  logic              found;
  logic              pick_none;

  always_comb begin
    elig = '0;
    vrow = '0;
    if (set_ok(victim_set)) begin
      elig = part(victim_thread);
      vrow = age_q[victim_set];
`ifdef CACHE_REPL_LOCK_EN
      elig = elig & ~lock_q[victim_set];
`endif
    end
    inv       = elig & ~valid_ways;
    pick      = '0;
    best_age  = '0;
    found     = 1'b0;
    pick_none = (elig == '0);
    if (inv != '0) begin
      for (int unsigned x = 0; x < WAYS_PER_SET; x++) begin
        if (inv[x] && !found) begin
          pick  = WAYS_W'(x);
          found = 1'b1;
        end
      end
    end else begin
      // Strict compare keeps the lowest index on equal ages.
      for (int unsigned x = 0; x < WAYS_PER_SET; x++) begin
        if (elig[x] && (!found || (vrow[x] > best_age))) begin
          pick     = WAYS_W'(x);
          best_age = vrow[x];
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
      victim_none  <= 1'b0;
    end else begin
      victim_valid <= victim_req;
      if (victim_req) begin
        victim_way  <= pick;
        victim_none <= pick_none;
      end
    end
  end

endmodule
